// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and parameter checks for the pipelined adder/subtractor
//
// Purpose: operation encoding and the BITS/STAGES legality check used at elaboration.
// Ports:   none (package).

package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_t;

  // A split is legal when every stage gets the same non-empty segment width.
  function automatic bit addsub_split_ok(input int bits, input int stages);
    return (stages >= 1) && (stages <= bits) && ((bits % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_segment.sv
// rtl/addsub_segment.sv - W-bit ripple-carry segment of the pipelined adder
//
// Purpose: purely combinational ripple-carry add of one operand segment.
// Ports:
//   a, b   in  W  operand segments (b already conditioned for subtract)
//   cin    in  1  carry into bit 0
//   sum    out W  segment sum
//   cout   out 1  carry out of the segment MSB
//   c_msb  out 1  carry into the segment MSB (for signed overflow)

module addsub_segment #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined two's-complement adder/subtractor with valid/ready
//
// Purpose: splits a BITS-wide add/subtract into STAGES segments, carrying between
//          them through pipeline registers; one operation per cycle, full backpressure.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready = pipeline advance)
//   a, b, cin, op         operands, carry/borrow-in, 0 = add, 1 = subtract
//   out_valid / out_ready result handshake
//   sum, cout, ovf, zero  result, carry out (1 = no borrow on subtract), signed overflow, sum == 0

module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            cin,
  input  logic            op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] sum,
  output logic            cout,
  output logic            ovf,
  output logic            zero
);

  localparam int SEG = BITS / STAGES;

  if (!addsub_split_ok(BITS, STAGES)) begin : g_bad_split
    $error("pipelined_addsub: BITS must be a multiple of STAGES with 1 <= STAGES <= BITS");
  end

  // Per-level state. Level k holds the operation after segment k has been added;
  // the last level is the output register. Operands travel full width so later
  // stages find their segment skewed, and finished low sum bits ride along de-skewed.
  logic [BITS-1:0] a_q  [STAGES];
  logic [BITS-1:0] b_q  [STAGES];
  logic [BITS-1:0] s_q  [STAGES];
  logic            c_q  [STAGES];
  logic            v_q  [STAGES];
  logic            cmsb [STAGES];
  logic            ovf_q;
  logic            zero_q;
  logic            advance;

  // The whole pipe moves in lock-step; a stalled output freezes every level.
  assign advance  = !v_q[STAGES-1] || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [BITS-1:0] src_a;
    logic [BITS-1:0] src_b;
    logic [BITS-1:0] src_s;
    logic            src_c;
    logic            src_v;
    logic [SEG-1:0]  seg_sum;
    logic            seg_cout;
    logic [BITS-1:0] s_next;

    if (k == 0) begin : g_head
      // Subtract is a + ~b + ~cin, so the borrow-in is inverted into a carry-in.
      assign src_a = a;
      assign src_b = (op == OP_SUB) ? ~b : b;
      assign src_c = (op == OP_SUB) ? ~cin : cin;
      assign src_s = '0;
      assign src_v = in_valid;
    end else begin : g_body
      assign src_a = a_q[k-1];
      assign src_b = b_q[k-1];
      assign src_c = c_q[k-1];
      assign src_s = s_q[k-1];
      assign src_v = v_q[k-1];
    end

    addsub_segment #(.W(SEG)) u_segment (
      .a     (src_a[k*SEG +: SEG]),
      .b     (src_b[k*SEG +: SEG]),
      .cin   (src_c),
      .sum   (seg_sum),
      .cout  (seg_cout),
      .c_msb (cmsb[k])
    );

    always_comb begin
      s_next                = src_s;
      s_next[k*SEG +: SEG]  = seg_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end else if (advance) begin
        a_q[k] <= src_a;
        b_q[k] <= src_b;
        s_q[k] <= s_next;
        c_q[k] <= seg_cout;
        v_q[k] <= src_v;
      end
    end

    if (k == STAGES - 1) begin : g_flags
      // Flags are registered with the final segment so they align with sum.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (advance) begin
          ovf_q  <= cmsb[k] ^ seg_cout;
          zero_q <= (s_next == '0);
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub

module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       in_valid8, in_ready8, cin8, op8, out_valid8, out_ready8, cout8, ovf8, zero8;
  logic [7:0] a8, b8, sum8;

  logic        in_valid16, in_ready16, cin16, op16, out_valid16, out_ready16, cout16, ovf16, zero16;
  logic [15:0] a16, b16, sum16;

  pipelined_addsub #(.BITS(8), .STAGES(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .op(op8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  pipelined_addsub #(.BITS(16), .STAGES(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .op(op16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated operation on the 8-bit/2-stage instance; checks latency and result.
  task automatic op8_check(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input logic vcin, input logic vop, input logic [10:0] exp);
    int lat;
    @(negedge clk);
    a8 = va; b8 = vb; cin8 = vcin; op8 = vop; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 2);
    check({tag, " result"}, {sum8, cout8, ovf8, zero8}, exp);
  endtask

  function automatic logic [18:0] model16(input logic [15:0] va, input logic [15:0] vb,
                                          input logic vc, input logic vo);
    logic [15:0] bb;
    logic        cc;
    logic [16:0] t;
    logic        v;
    bb = vo ? ~vb : vb;
    cc = vo ? ~vc : vc;
    t  = {1'b0, va} + {1'b0, bb} + {16'd0, cc};
    v  = (va[15] == bb[15]) && (t[15] != va[15]);
    return {t[15:0], t[16], v, (t[15:0] == 16'd0)};
  endfunction

  // Back-to-back stream: operands and expected {sum, cout, ovf, zero}.
  logic [7:0]  bp_a   [4] = '{8'h12, 8'h70, 8'h10, 8'hFF};
  logic [7:0]  bp_b   [4] = '{8'h34, 8'h20, 8'h20, 8'hFF};
  logic        bp_cin [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic        bp_op  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [10:0] bp_exp [4] = '{{8'h46, 3'b000}, {8'h90, 3'b010}, {8'hF0, 3'b000}, {8'hFF, 3'b100}};

  logic [18:0] q16 [$];
  logic [10:0] hold;
  int          sent, got, stall, stale;
  bit          seen_valid, have_hold;

  initial begin
    rst_n = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; op8 = 1'b0; out_ready8 = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; op16 = 1'b0; out_ready16 = 1'b1;

    #12;
    check("reset out_valid", out_valid8, 0);
    check("reset flags", {sum8, cout8, ovf8, zero8}, 0);
    check("reset in_ready", in_ready8, 1);
    check("reset out_valid16", out_valid16, 0);
    check("reset in_ready16", in_ready16, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, expected {sum, cout, ovf, zero}.
    op8_check("add ovf 7F+01",   8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 3'b010});
    op8_check("sub borrow 00-01", 8'h00, 8'h01, 1'b0, 1'b1, {8'hFF, 3'b000});
    op8_check("sub ovf 80-01",   8'h80, 8'h01, 1'b0, 1'b1, {8'h7F, 3'b110});
    op8_check("add wrap FF+00+1", 8'hFF, 8'h00, 1'b1, 1'b0, {8'h00, 3'b101});
    op8_check("sub bin 05-03-1", 8'h05, 8'h03, 1'b1, 1'b1, {8'h01, 3'b100});
    op8_check("add 80+80",       8'h80, 8'h80, 1'b0, 1'b0, {8'h00, 3'b111});
    op8_check("sub eq 5A-5A",    8'h5A, 8'h5A, 1'b0, 1'b1, {8'h00, 3'b101});

    // Streaming with a 3-cycle stall after the first result.
    sent = 0; got = 0; stall = 0; seen_valid = 0; have_hold = 0; hold = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (sent < 4) begin
        a8 = bp_a[sent]; b8 = bp_b[sent]; cin8 = bp_cin[sent]; op8 = bp_op[sent];
        in_valid8 = 1'b1;
      end else begin
        in_valid8 = 1'b0;
      end
      if (out_valid8 && !seen_valid) begin
        seen_valid = 1;
        stall = 3;
      end
      out_ready8 = (stall == 0);
      #1;
      if (out_valid8 && !out_ready8) begin
        check("bp in_ready low", in_ready8, 0);
        if (have_hold) check("bp hold stable", {sum8, cout8, ovf8, zero8}, hold);
        hold = {sum8, cout8, ovf8, zero8};
        have_hold = 1;
        stall--;
      end
      if (in_valid8 && in_ready8) sent++;
      if (out_valid8 && out_ready8) begin
        if (got < 4) check($sformatf("bp result %0d", got), {sum8, cout8, ovf8, zero8}, bp_exp[got]);
        got++;
      end
    end
    in_valid8 = 1'b0;
    check("bp all sent", sent, 4);
    check("bp count", got, 4);

    // Reset with two operations in flight.
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; op8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h01; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    check("rst pre out_valid", out_valid8, 1);
    rst_n = 1'b0;
    #1;
    check("rst out_valid drop", out_valid8, 0);
    check("rst data clear", {sum8, cout8, ovf8, zero8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready8 = 1'b1;
    stale = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (out_valid8) stale++;
    end
    check("rst no stale", stale, 0);
    op8_check("post rst 40+02", 8'h40, 8'h02, 1'b0, 1'b0, {8'h42, 3'b000});

    // Random stream on the 16-bit/4-stage instance against the reference model.
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 20000 && (sent < 2000 || q16.size() > 0); cyc++) begin
      @(negedge clk);
      in_valid16  = (sent < 2000) && ($urandom_range(3) != 0);
      a16         = 16'($urandom);
      b16         = 16'($urandom);
      cin16       = 1'($urandom);
      op16        = 1'($urandom);
      out_ready16 = ($urandom_range(3) != 0);
      #1;
      if (in_valid16 && in_ready16) begin
        q16.push_back(model16(a16, b16, cin16, op16));
        sent++;
      end
      if (out_valid16 && out_ready16) begin
        if (q16.size() > 0) check("rnd result", {sum16, cout16, ovf16, zero16}, q16.pop_front());
        got++;
      end
    end
    check("rnd sent", sent, 2000);
    check("rnd received", got, 2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
